miner_nonce_dispatcher: RTL and testbench

Job-side controller driving the other end of the miner core start/done interface. It accepts a job (nonce range plus target), issues one hash_enable pulse per nonce and waits for the core's finished pulse. It compares each returned 256-bit digest against the target and reports a result: found, exhausted, timeout or aborted. It sits between the host/job interface and miner_core_CCU.

---
 rtl/miner_nonce_dispatcher.sv | 157 +++++++++++++++
 tb/tb_miner_nonce_dispatcher.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miner_nonce_dispatcher.sv
// Job-side controller for the miner core start/done handshake.
// Accepts a nonce range plus target, issues one hash_enable pulse per nonce,
// waits for the core's finished pulse, compares each digest against the target
// and reports found / exhausted / timeout / aborted to the host.

module miner_nonce_dispatcher #(
   parameter int unsigned NONCE_W = 32,
   parameter int unsigned HASH_W  = 256,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               n_rst,
   // job interface
   input  logic               job_valid,
   output logic               job_ready,
   input  logic [NONCE_W-1:0] nonce_start,
   input  logic [NONCE_W-1:0] nonce_end,
   input  logic [HASH_W-1:0]  target,
   input  logic               abort,
   // core interface
   output logic               hash_enable,
   output logic [NONCE_W-1:0] nonce,
   input  logic               finished,
   input  logic [HASH_W-1:0]  hash_in,
   // result interface
   output logic               result_valid,
   input  logic               result_ready,
   output logic [1:0]         status,
   output logic [NONCE_W-1:0] found_nonce,
   output logic [NONCE_W-1:0] attempts,
   output logic               busy
);

   // Timer only has to reach TIMEOUT-1, so clog2 bits are enough.
   localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

   localparam logic [1:0] StatFound     = 2'b00;
   localparam logic [1:0] StatExhausted = 2'b01;
   localparam logic [1:0] StatTimeout   = 2'b10;
   localparam logic [1:0] StatAborted   = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StCheck,
      StDone
   } state_e;

   state_e              state_q;
   logic [NONCE_W-1:0]  nonce_q;
   logic [NONCE_W-1:0]  nonce_end_q;
   logic [HASH_W-1:0]   target_q;
   logic [HASH_W-1:0]   hash_q;
   logic [TimerW-1:0]   timer_q;
   logic [1:0]          status_q;
   logic [NONCE_W-1:0]  found_q;
   logic [NONCE_W-1:0]  attempts_q;

   // Job sequencing FSM: all state, counters and result registers live here.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= StIdle;
         nonce_q     <= '0;
         nonce_end_q <= '0;
         target_q    <= '0;
         hash_q      <= '0;
         timer_q     <= '0;
         status_q    <= StatFound;
         found_q     <= '0;
         attempts_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               // job_ready is high throughout IDLE, so job_valid alone is the handshake
               if (job_valid) begin
                  nonce_q     <= nonce_start;
                  nonce_end_q <= nonce_end;
                  target_q    <= target;
                  attempts_q  <= '0;
                  found_q     <= '0;
                  status_q    <= StatFound;
                  state_q     <= StIssue;
               end
            end

            StIssue: begin
               timer_q <= '0;
               if (abort) begin
                  status_q <= StatAborted;
                  state_q  <= StDone;
               end else begin
                  state_q <= StWait;
               end
            end

            StWait: begin
               timer_q <= timer_q + TimerW'(1);
               // abort beats finished, finished beats the timeout in the same cycle
               if (abort) begin
                  status_q <= StatAborted;
                  state_q  <= StDone;
               end else if (finished) begin
                  hash_q <= hash_in;
                  if (attempts_q != '1) begin
                     attempts_q <= attempts_q + NONCE_W'(1);
                  end
                  state_q <= StCheck;
               end else if (timer_q == TimerLast) begin
                  status_q <= StatTimeout;
                  state_q  <= StDone;
               end
            end

            StCheck: begin
               if (abort) begin
                  status_q <= StatAborted;
                  state_q  <= StDone;
               end else if (hash_q < target_q) begin
                  found_q  <= nonce_q;
                  status_q <= StatFound;
                  state_q  <= StDone;
               end else if (nonce_q == nonce_end_q) begin
                  status_q <= StatExhausted;
                  state_q  <= StDone;
               end else begin
                  // modular increment gives the wrap from all-ones back to zero
                  nonce_q <= nonce_q + NONCE_W'(1);
                  state_q <= StIssue;
               end
            end

            StDone: begin
               if (result_ready) begin
                  state_q <= StIdle;
               end
            end

            default: state_q <= StIdle;
         endcase
      end
   end

   // Handshake outputs decoded from the registered state; an abort in ISSUE
   // must suppress the start pulse in that same cycle.
   assign job_ready    = (state_q == StIdle);
   assign busy         = (state_q != StIdle);
   assign result_valid = (state_q == StDone);
   assign hash_enable  = (state_q == StIssue) && !abort;

   assign nonce        = nonce_q;
   assign status       = status_q;
   assign found_nonce  = found_q;
   assign attempts     = attempts_q;

endmodule

// File: tb/tb_miner_nonce_dispatcher.sv
// Bench for miner_nonce_dispatcher: a core stub answers hash_enable pulses, a
// job-level model predicts issue cycles, nonces and the final result from the
// job parameters, and one per-cycle compare step checks the DUT against it.

module tb_miner_nonce_dispatcher;

   localparam int unsigned NW  = 32;
   localparam int unsigned HW  = 256;
   localparam int          TMO = 16;

   logic          clk;
   logic          n_rst;
   logic          job_valid;
   logic          job_ready;
   logic [NW-1:0] nonce_start;
   logic [NW-1:0] nonce_end;
   logic [HW-1:0] target;
   logic          abort;
   logic          hash_enable;
   logic [NW-1:0] nonce;
   logic          finished;
   logic [HW-1:0] hash_in;
   logic          result_valid;
   logic          result_ready;
   logic [1:0]    status;
   logic [NW-1:0] found_nonce;
   logic [NW-1:0] attempts;
   logic          busy;

   miner_nonce_dispatcher #(
      .NONCE_W (NW),
      .HASH_W  (HW),
      .TIMEOUT (TMO)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .job_valid    (job_valid),
      .job_ready    (job_ready),
      .nonce_start  (nonce_start),
      .nonce_end    (nonce_end),
      .target       (target),
      .abort        (abort),
      .hash_enable  (hash_enable),
      .nonce        (nonce),
      .finished     (finished),
      .hash_in      (hash_in),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .status       (status),
      .found_nonce  (found_nonce),
      .attempts     (attempts),
      .busy         (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp;
   int n_fail;
   int cyc;

   // stimulus configuration
   int            stub_lat;
   bit            stub_on;
   bit            stub_double;
   bit            hit_en;
   bit            eq_en;
   logic [NW-1:0] hit_n;
   logic [NW-1:0] eq_n;
   logic [HW-1:0] cur_target;
   int            abort_off;
   bit            force_abort;

   // core stub state
   bit            stub_pend;
   int            stub_due;
   logic [NW-1:0] stub_n;

   // model state
   bit            mon_en;
   bit            active;
   bit            issue_checked;
   int            acc_cyc;
   int            m_done;
   int            idx;
   logic [NW-1:0] q_n[$];
   int            q_c[$];
   logic [1:0]    m_status;
   logic [NW-1:0] m_att;
   logic [NW-1:0] m_found;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Digest the stub returns for a nonce.
   function automatic logic [HW-1:0] hash_of(input logic [NW-1:0] n);
      if (hit_en && n == hit_n) return 256'd1;
      if (eq_en && n == eq_n) return cur_target;
      return '1;
   endfunction

   // Walk the job nonce by nonce and record when each start pulse must appear
   // and how the job ends.
   task automatic model_job(input logic [NW-1:0] s, input logic [NW-1:0] e,
                            input logic [HW-1:0] t);
      logic [NW-1:0] n;
      int ti, tf, tc, ab;
      bit fin;
      q_n.delete();
      q_c.delete();
      idx = 0;
      issue_checked = 0;
      m_att = '0;
      m_found = '0;
      m_status = 2'b00;
      ab = (abort_off > 0) ? acc_cyc + abort_off : -1;
      n = s;
      ti = acc_cyc + 1;
      fin = 0;
      while (!fin) begin
         if (ab >= 0 && ab == ti) begin
            m_status = 2'b11; m_done = ti + 1; fin = 1;
         end else begin
            q_n.push_back(n);
            q_c.push_back(ti);
            if (!stub_on) begin
               if (ab >= 0 && ab <= ti + TMO) begin
                  m_status = 2'b11; m_done = ab + 1;
               end else begin
                  m_status = 2'b10; m_done = ti + TMO + 1;
               end
               fin = 1;
            end else begin
               tf = ti + stub_lat;
               if (ab >= 0 && ab <= tf) begin
                  m_status = 2'b11; m_done = ab + 1; fin = 1;
               end else begin
                  if (m_att != 32'hFFFF_FFFF) m_att = m_att + 1;
                  tc = tf + 1;
                  if (ab == tc) begin
                     m_status = 2'b11; m_done = tc + 1; fin = 1;
                  end else if (hash_of(n) < t) begin
                     m_status = 2'b00; m_found = n; m_done = tc + 1; fin = 1;
                  end else if (n == e) begin
                     m_status = 2'b01; m_done = tc + 1; fin = 1;
                  end else begin
                     n = n + 1;
                     ti = tc + 1;
                  end
               end
            end
         end
      end
   endtask

   // Per-cycle comparison against the model, sampled at the falling edge.
   task automatic monitor_step();
      bit exp_he;
      if (mon_en) begin
         if (!active) begin
            check("idle_job_ready", job_ready, 1'b1);
            check("idle_busy", busy, 1'b0);
            check("idle_result_valid", result_valid, 1'b0);
            check("idle_hash_enable", hash_enable, 1'b0);
            if (job_valid && job_ready) begin
               acc_cyc = cyc;
               model_job(nonce_start, nonce_end, target);
               active = 1;
            end
         end else begin
            exp_he = 0;
            if (idx < q_n.size()) begin
               if (cyc == q_c[idx]) exp_he = 1;
            end
            check("hash_enable", hash_enable, exp_he);
            if (exp_he) begin
               check("nonce", nonce, q_n[idx]);
               idx++;
            end
            check("busy", busy, 1'b1);
            check("job_ready", job_ready, 1'b0);
            check("result_valid", result_valid, cyc >= m_done);
            if (cyc >= m_done) begin
               if (!issue_checked) begin
                  check("issue_count", idx, q_n.size());
                  issue_checked = 1;
               end
               check("status", status, m_status);
               check("attempts", attempts, m_att);
               if (m_status == 2'b00) check("found_nonce", found_nonce, m_found);
               if (result_ready) active = 0;
            end
         end
      end
      if (stub_on && hash_enable) begin
         stub_pend = 1;
         stub_due  = cyc + stub_lat;
         stub_n    = nonce;
      end
   endtask

   task automatic drive_stub();
      finished = 1'b0;
      if (stub_pend && cyc == stub_due) begin
         finished = 1'b1;
         hash_in  = hash_of(stub_n);
         if (!stub_double) stub_pend = 0;
      end else if (stub_pend && cyc == stub_due + 1) begin
         finished  = 1'b1;
         stub_pend = 0;
      end
      abort = force_abort || (active && abort_off > 0 && cyc == acc_cyc + abort_off);
   endtask

   task automatic tick();
      @(negedge clk);
      monitor_step();
      @(posedge clk);
      cyc++;
      #1;
      drive_stub();
   endtask

   task automatic setup(input int lat, input bit on, input bit dbl, input bit hen,
                        input logic [NW-1:0] hn, input bit een, input logic [NW-1:0] en,
                        input int aoff);
      stub_lat = lat; stub_on = on; stub_double = dbl;
      hit_en = hen; hit_n = hn; eq_en = een; eq_n = en; abort_off = aoff;
   endtask

   task automatic run_job(input logic [NW-1:0] s, input logic [NW-1:0] e,
                          input logic [HW-1:0] t);
      int k;
      nonce_start = s; nonce_end = e; target = t; cur_target = t;
      job_valid = 1'b1;
      tick();
      job_valid = 1'b0;
      k = 0;
      while (!result_valid && k < 300) begin
         tick();
         k++;
      end
      check("result_seen", result_valid, 1'b1);
   endtask

   task automatic consume(input int hold);
      repeat (hold) begin
         check("hold_job_ready", job_ready, 1'b0);
         tick();
      end
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      check("idle_after_ack", job_ready, 1'b1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_job_ready"}, job_ready, 1'b1);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_result_valid"}, result_valid, 1'b0);
      check({tag, "_hash_enable"}, hash_enable, 1'b0);
      check({tag, "_nonce"}, nonce, 32'd0);
      check({tag, "_status"}, status, 2'b00);
      check({tag, "_attempts"}, attempts, 32'd0);
      check({tag, "_found"}, found_nonce, 32'd0);
   endtask

   initial begin
      n_cmp = 0; n_fail = 0; cyc = 0;
      n_rst = 1'b0; job_valid = 1'b0; nonce_start = '0; nonce_end = '0; target = '0;
      abort = 1'b0; finished = 1'b0; hash_in = '0; result_ready = 1'b0;
      force_abort = 0; stub_pend = 0; stub_due = 0; stub_n = '0;
      mon_en = 0; active = 0; issue_checked = 0; acc_cyc = 0; m_done = 0; idx = 0;
      m_status = 2'b00; m_att = '0; m_found = '0; cur_target = '0;
      setup(1, 1, 0, 0, 32'd0, 0, 32'd0, -1);
      #3;
      check_reset_values("rst");
      tick();
      tick();
      n_rst = 1'b1;
      mon_en = 1;
      tick();

      // found on first nonce; stray finished in CHECK and abort in DONE are ignored
      setup(1, 1, 1, 1, 32'd5, 0, 32'd0, -1);
      run_job(32'd5, 32'd9, 256'd1 << 255);
      check("found_status", status, 2'b00);
      check("found_nonce_lit", found_nonce, 32'd5);
      check("found_attempts", attempts, 32'd1);
      force_abort = 1;
      consume(2);
      force_abort = 0;

      // exhausted 10..12
      setup(3, 1, 0, 0, 32'd0, 0, 32'd0, -1);
      run_job(32'd10, 32'd12, 256'd1 << 255);
      check("exh_status", status, 2'b01);
      check("exh_attempts", attempts, 32'd3);
      consume(0);

      // wrap FFFFFFFE..1
      setup(2, 1, 0, 0, 32'd0, 0, 32'd0, -1);
      run_job(32'hFFFF_FFFE, 32'd1, 256'd1 << 255);
      check("wrap_status", status, 2'b01);
      check("wrap_attempts", attempts, 32'd4);
      consume(1);

      // hash == target is a miss; finished on the timeout cycle still wins
      setup(TMO, 1, 0, 1, 32'd21, 1, 32'd20, -1);
      run_job(32'd20, 32'd30, 256'h1234);
      check("eq_status", status, 2'b00);
      check("eq_found", found_nonce, 32'd21);
      check("eq_attempts", attempts, 32'd2);
      consume(0);

      // timeout: core never answers
      setup(1, 0, 0, 0, 32'd0, 0, 32'd0, -1);
      run_job(32'd7, 32'd8, 256'd1 << 255);
      check("tmo_latency", cyc - acc_cyc, 18);
      check("tmo_status", status, 2'b10);
      check("tmo_attempts", attempts, 32'd0);
      consume(0);

      // abort together with the second finished, then back-pressure
      setup(2, 1, 0, 0, 32'd0, 0, 32'd0, 7);
      run_job(32'd30, 32'd40, 256'd1 << 255);
      repeat (5) begin
         check("bp_status", status, 2'b11);
         check("bp_attempts", attempts, 32'd1);
         tick();
      end
      consume(0);

      // abort in ISSUE suppresses the start pulse
      setup(1, 1, 0, 0, 32'd0, 0, 32'd0, 1);
      run_job(32'd50, 32'd60, 256'd1 << 255);
      check("abi_status", status, 2'b11);
      check("abi_attempts", attempts, 32'd0);
      consume(0);

      // abort in CHECK beats a hit
      setup(1, 1, 0, 1, 32'd50, 0, 32'd0, 3);
      run_job(32'd50, 32'd60, 256'd1 << 255);
      check("abc_status", status, 2'b11);
      check("abc_attempts", attempts, 32'd1);
      consume(0);

      // start == end hashes exactly one nonce
      setup(1, 1, 0, 0, 32'd0, 0, 32'd0, -1);
      run_job(32'd100, 32'd100, 256'd1 << 255);
      check("one_status", status, 2'b01);
      check("one_attempts", attempts, 32'd1);
      consume(0);

      // reset while waiting on the core
      setup(1, 0, 0, 0, 32'd0, 0, 32'd0, -1);
      nonce_start = 32'd0; nonce_end = 32'd5; target = 256'd1 << 255; cur_target = target;
      job_valid = 1'b1;
      tick();
      job_valid = 1'b0;
      repeat (4) tick();
      check("pre_rst_busy", busy, 1'b1);
      #2;
      n_rst = 1'b0;
      #1;
      check_reset_values("mid_rst");
      mon_en = 0; active = 0; stub_pend = 0;
      tick();
      tick();
      n_rst = 1'b1;
      mon_en = 1;
      tick();
      setup(1, 1, 0, 1, 32'd3, 0, 32'd0, -1);
      run_job(32'd3, 32'd3, 256'd1 << 255);
      check("post_rst_status", status, 2'b00);
      check("post_rst_found", found_nonce, 32'd3);
      check("post_rst_attempts", attempts, 32'd1);
      consume(0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
